mem_wb_pipe: RTL and testbench

//  Parametrised MEM->WB pipeline register for the multi-issue core; successor to the single-lane MEM/WB latch.

---
 rtl/mem_wb_pipe.sv | 116 +++++++++++
 tb/tb_mem_wb_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register for the multi-issue core: NLANES GPR write ports plus HI/LO,
// with flush/bubble/hold control, write-collision resolution and saturating perf counters.
module mem_wb_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NLANES  = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic [NLANES*ADDR_W-1:0] mem_wd,
    input  logic [NLANES-1:0]        mem_wreg,
    input  logic [NLANES*DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     mem_whilo,
    output logic [NLANES*ADDR_W-1:0] wb_wd,
    output logic [NLANES-1:0]        wb_wreg,
    output logic [NLANES*DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     wb_whilo,
    output logic                     wb_valid,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int PC_W = $clog2(NLANES + 1);

    // r0 writes are dropped; an older lane loses to any younger lane writing the same register.
    function automatic logic [NLANES-1:0] resolve_wreg(
        input logic [NLANES*ADDR_W-1:0] wd,
        input logic [NLANES-1:0]        wreg
    );
        logic [NLANES-1:0] en;
        en = wreg;
        for (int i = 0; i < NLANES; i++) begin
            en[i] = en[i] & (wd[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}});
            for (int j = i + 1; j < NLANES; j++) begin
                en[i] = en[i] & ~(wreg[j] & (wd[j*ADDR_W +: ADDR_W] == wd[i*ADDR_W +: ADDR_W]));
            end
        end
        return en;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [NLANES-1:0] v);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int k = 0; k < NLANES; k++) begin
            c = c + PC_W'(v[k]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [PC_W-1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [NLANES-1:0] res_wreg_s;
    logic [PC_W-1:0]   inc_s;
    logic              valid_s;
    logic              bubble_s;
    logic              hold_s;
    logic              unused_stall_s;

    assign unused_stall_s = ^stall;

    // Resolve lane enables and decide this edge's action from the stall pair and flush.
    always_comb begin
        res_wreg_s = resolve_wreg(mem_wd, mem_wreg);
        inc_s      = popcount(res_wreg_s);
        valid_s    = (|res_wreg_s) | mem_whilo;
        bubble_s   = flush | (stall[STAGE] & ~stall[STAGE+1]);
        hold_s     = stall[STAGE];
    end

    // Pipeline register and counters: flush/bubble clears, hold keeps, otherwise advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wd      <= '0;
            wb_wreg    <= '0;
            wb_wdata   <= '0;
            wb_hi      <= '0;
            wb_lo      <= '0;
            wb_whilo   <= 1'b0;
            wb_valid   <= 1'b0;
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else if (bubble_s) begin
            wb_wd      <= '0;
            wb_wreg    <= '0;
            wb_wdata   <= '0;
            wb_hi      <= '0;
            wb_lo      <= '0;
            wb_whilo   <= 1'b0;
            wb_valid   <= 1'b0;
            bubble_cnt <= sat_add(bubble_cnt, PC_W'(1'b1));
        end else if (!hold_s) begin
            wb_wd      <= mem_wd;
            wb_wreg    <= res_wreg_s;
            wb_wdata   <= mem_wdata;
            wb_hi      <= mem_hi;
            wb_lo      <= mem_lo;
            wb_whilo   <= mem_whilo;
            wb_valid   <= valid_s;
            retire_cnt <= sat_add(retire_cnt, inc_s);
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a reference model pushes expected register contents into a
// queue per stimulus step; results are popped and compared one cycle later.
module tb_mem_wb_pipe;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [9:0]  mem_wd;
    logic [1:0]  mem_wreg;
    logic [63:0] mem_wdata;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_whilo;

    logic [9:0]  wb_wd;
    logic [1:0]  wb_wreg;
    logic [63:0] wb_wdata;
    logic [31:0] wb_hi, wb_lo;
    logic        wb_whilo, wb_valid;
    logic [31:0] retire_cnt, bubble_cnt;

    logic [9:0]  s_wd;
    logic [1:0]  s_wreg;
    logic [63:0] s_wdata;
    logic [31:0] s_hi, s_lo;
    logic        s_whilo, s_valid;
    logic [3:0]  s_retire, s_bubble;

    mem_wb_pipe dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .wb_valid(wb_valid),
        .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    mem_wb_pipe #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_wdata(s_wdata),
        .wb_hi(s_hi), .wb_lo(s_lo), .wb_whilo(s_whilo), .wb_valid(s_valid),
        .retire_cnt(s_retire), .bubble_cnt(s_bubble)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
        logic [31:0] hi, lo;
        logic        whilo, valid;
        longint      ret, bub, ret4, bub4;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m = '{wd: '0, wreg: '0, wdata: '0, hi: '0, lo: '0, whilo: 1'b0, valid: 1'b0,
              ret: 0, bub: 0, ret4: 0, bub4: 0};
    endtask

    task automatic model_bubble();
        m.wd = '0; m.wreg = '0; m.wdata = '0; m.hi = '0; m.lo = '0;
        m.whilo = 1'b0; m.valid = 1'b0;
        m.bub  = (m.bub + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m.bub + 1;
        m.bub4 = (m.bub4 + 1 > 15) ? 15 : m.bub4 + 1;
    endtask

    // Reference model of one clock edge, evaluated before the edge on the driven inputs.
    task automatic tick(input string tag);
        logic [4:0] a0, a1;
        logic       en0, en1;
        int         n;
        a0 = mem_wd[4:0];
        a1 = mem_wd[9:5];
        if (flush) model_bubble();
        else if (stall[4] && !stall[5]) model_bubble();
        else if (!stall[4]) begin
            en1 = mem_wreg[1] && (a1 != 5'd0);
            en0 = mem_wreg[0] && (a0 != 5'd0) && !(mem_wreg[1] && (a1 == a0));
            n = int'(en0) + int'(en1);
            m.wd = mem_wd; m.wreg = {en1, en0}; m.wdata = mem_wdata;
            m.hi = mem_hi; m.lo = mem_lo; m.whilo = mem_whilo;
            m.valid = en0 | en1 | mem_whilo;
            m.ret  = (m.ret + n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m.ret + n;
            m.ret4 = (m.ret4 + n > 15) ? 15 : m.ret4 + n;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wd"},    64'(wb_wd),      64'(e.wd));
            chk({tag, "_wreg"},  64'(wb_wreg),    64'(e.wreg));
            chk({tag, "_wdata"}, wb_wdata,        e.wdata);
            chk({tag, "_hi"},    64'(wb_hi),      64'(e.hi));
            chk({tag, "_lo"},    64'(wb_lo),      64'(e.lo));
            chk({tag, "_whilo"}, 64'(wb_whilo),   64'(e.whilo));
            chk({tag, "_valid"}, 64'(wb_valid),   64'(e.valid));
            chk({tag, "_ret"},   64'(retire_cnt), 64'(e.ret));
            chk({tag, "_bub"},   64'(bubble_cnt), 64'(e.bub));
            chk({tag, "_ret4"},  64'(s_retire),   64'(e.ret4));
            chk({tag, "_bub4"},  64'(s_bubble),   64'(e.bub4));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wd"},    64'(wb_wd), 64'h0);
        chk({tag, "_wreg"},  64'(wb_wreg), 64'h0);
        chk({tag, "_wdata"}, wb_wdata, 64'h0);
        chk({tag, "_hilo"},  {wb_hi, wb_lo}, 64'h0);
        chk({tag, "_flags"}, 64'({wb_whilo, wb_valid}), 64'h0);
        chk({tag, "_cnts"},  {retire_cnt, bubble_cnt}, 64'h0);
        chk({tag, "_sat"},   64'({s_retire, s_bubble, s_valid}), 64'h0);
    endtask

    task automatic set_in(input logic [4:0] wd1, input logic [4:0] wd0, input logic [1:0] wreg,
                          input logic [31:0] d1, input logic [31:0] d0,
                          input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
        mem_wd = {wd1, wd0}; mem_wreg = wreg; mem_wdata = {d1, d0};
        mem_hi = hi; mem_lo = lo; mem_whilo = whilo;
    endtask

    initial begin
        // 1: async reset with random inputs and no clock edge
        rst = 1'b0;
        stall = 6'($urandom); flush = 1'($urandom);
        mem_wd = 10'($urandom); mem_wreg = 2'($urandom);
        mem_wdata = {$urandom, $urandom};
        mem_hi = $urandom; mem_lo = $urandom; mem_whilo = 1'($urandom);
        model_reset();
        #2;
        check_zero("reset");
        #1;
        rst = 1'b1;
        stall = 6'b000000; flush = 1'b0;
        set_in(5'd0, 5'd3, 2'b01, 32'h0, 32'hAA, 32'h0, 32'h0, 1'b0);
        tick("first_adv");

        // 2: bubble, then hold with changing inputs
        set_in(5'd9, 5'd8, 2'b11, 32'h55, 32'h66, 32'h1, 32'h2, 1'b1);
        stall = 6'b010000;
        tick("bubble");
        stall = 6'b000000;
        tick("adv_pre_hold");
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            set_in(5'(i + 1), 5'(i + 10), 2'b11, $urandom, $urandom, $urandom, $urandom, 1'b1);
            tick("hold");
        end

        // 3: collisions and r0 suppression
        stall = 6'b000000;
        set_in(5'd7, 5'd7, 2'b11, 32'h22, 32'h11, 32'h0, 32'h0, 1'b0);
        tick("collide");
        set_in(5'd5, 5'd0, 2'b01, 32'h0, 32'h33, 32'h0, 32'h0, 1'b0);
        tick("r0_lane0");
        set_in(5'd0, 5'd0, 2'b11, 32'h44, 32'h33, 32'h0, 32'h0, 1'b0);
        tick("r0_both");
        set_in(5'd4, 5'd3, 2'b11, 32'h44, 32'h33, 32'h0, 32'h0, 1'b0);
        tick("distinct");
        set_in(5'd6, 5'd6, 2'b01, 32'h77, 32'h88, 32'h0, 32'h0, 1'b0);
        tick("same_addr_old_only");

        // 4: flush beats hold, and flush while advancing
        set_in(5'd2, 5'd1, 2'b11, 32'h12, 32'h34, 32'h5, 32'h6, 1'b1);
        stall = 6'b110000; flush = 1'b1;
        tick("flush_hold");
        stall = 6'b000000;
        tick("flush_adv");
        flush = 1'b0;

        // 5: HI/LO only
        set_in(5'd2, 5'd1, 2'b00, 32'h0, 32'h0, 32'hDEAD, 32'hBEEF, 1'b1);
        tick("hilo");

        // 6: saturation of the narrow counters, then async reset mid-run
        for (int i = 0; i < 20; i++) begin
            set_in(5'd2, 5'd1, 2'b11, $urandom, $urandom, 32'h0, 32'h0, 1'b0);
            tick("sat_retire");
        end
        flush = 1'b1;
        for (int i = 0; i < 14; i++) tick("sat_bubble");
        flush = 1'b0;
        set_in(5'd2, 5'd1, 2'b11, 32'h9, 32'h8, 32'h0, 32'h0, 1'b0);
        tick("pre_rst");
        rst = 1'b0;
        #1;
        model_reset();
        check_zero("mid_rst");
        #1;
        rst = 1'b1;
        tick("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
